// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
// Included by pc_unit and pc_ras; the optional RAS is selected with PC_RAS_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored. data_out always shows the current top entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW:0]   CAP = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;   // next slot to write; top-1 is the newest entry
  logic [PW:0]      count;

  assign data_out = mem[top - ONE];
  assign empty    = (count == '0);
  assign full     = (count == CAP);

  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem[top] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
    end else if (pop) begin
      if (!empty) begin
        top   <= top - ONE;
        count <= count - 1'b1;
      end
    end else if (push) begin
      top <= top + ONE;
      if (!full) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with BOOT/RUN/TRAP sequencing and misaligned-redirect trap.
// Define PC_RAS_EN to build the return-address stack for call/ret redirects.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                 ADDRESS   = 32,
  parameter logic [ADDRESS-1:0] RESET_VEC = ADDRESS'(DEFAULT_RESET_VEC),
  parameter logic [ADDRESS-1:0] TRAP_VEC  = ADDRESS'(DEFAULT_TRAP_VEC),
  parameter int                 RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               address_ready,
  input  logic               redirect_valid,
  input  logic [ADDRESS-1:0] redirect_target,
  input  logic               redirect_is_call,
  input  logic               redirect_is_ret,
  output logic [ADDRESS-1:0] address_out,
  output logic               address_valid,
  output logic               misalign,
  output logic [ADDRESS-1:0] bad_addr
);

  // Handshake: address_out is consumed on an edge where address_valid and
  // address_ready are both high; a redirect is taken only while in RUN and
  // does not wait for address_ready.
  pc_state_t          state;
  logic [ADDRESS-1:0] pc_plus4;
  logic [ADDRESS-1:0] dest;
  logic               take_redirect;

  assign pc_plus4      = address_out + ADDRESS'(4);
  assign take_redirect = (state == RUN) && redirect_valid;

`ifdef PC_RAS_EN
  logic [ADDRESS-1:0] ras_top;
  logic               ras_empty;
  logic               unused_ras_full;
  logic               ras_push;
  logic               ras_pop;

  // A redirect flagged both call and return is treated as a return only.
  assign ras_pop  = take_redirect && redirect_is_ret;
  assign ras_push = take_redirect && redirect_is_call && !redirect_is_ret;

  pc_ras #(
    .WIDTH (ADDRESS),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .data_in  (pc_plus4),
    .data_out (ras_top),
    .empty    (ras_empty),
    .full     (unused_ras_full)
  );

  assign dest = (redirect_is_ret && !ras_empty) ? ras_top : redirect_target;
`else
  logic unused_ras_flags;
  assign unused_ras_flags = redirect_is_call ^ redirect_is_ret;
  assign dest             = redirect_target;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      address_out   <= RESET_VEC;
      address_valid <= 1'b0;
      misalign      <= 1'b0;
      bad_addr      <= '0;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          address_out   <= RESET_VEC;
          address_valid <= 1'b1;
          misalign      <= 1'b0;
        end
        RUN: begin
          misalign <= 1'b0;
          if (take_redirect) begin
            if (dest[1:0] != 2'b00) begin
              state         <= TRAP;
              address_out   <= TRAP_VEC;
              address_valid <= 1'b0;
              misalign      <= 1'b1;
              bad_addr      <= dest;
            end else begin
              address_out <= dest;
            end
          end else if (address_ready) begin
            address_out <= pc_plus4;
          end
        end
        TRAP: begin
          state         <= RUN;
          address_valid <= 1'b1;
          misalign      <= 1'b0;
        end
        default: begin
          state         <= BOOT;
          address_out   <= RESET_VEC;
          address_valid <= 1'b0;
          misalign      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand-written RAS
// sequences (when PC_RAS_EN is defined) and random traffic against a model.
module tb_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        address_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_is_call;
  logic        redirect_is_ret;
  logic [31:0] address_out;
  logic        address_valid;
  logic        misalign;
  logic [31:0] bad_addr;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .ADDRESS   (32),
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address_ready    (address_ready),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .redirect_is_call (redirect_is_call),
    .redirect_is_ret  (redirect_is_ret),
    .address_out      (address_out),
    .address_valid    (address_valid),
    .misalign         (misalign),
    .bad_addr         (bad_addr)
  );

  always #5 clk = ~clk;

  // Behavioural reference: PC value, flags and a return-address queue.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_bad;
  bit          m_booting;
  bit          m_trapped;
  logic [31:0] m_ras[$];

  task automatic model_step();
    logic [31:0] dest;
    if (rst) begin
      m_pc = RESET_VEC; m_valid = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
      m_booting = 1'b1; m_trapped = 1'b0;
      m_ras.delete();
    end else if (m_booting) begin
      m_booting = 1'b0; m_valid = 1'b1; m_pc = RESET_VEC;
    end else if (m_trapped) begin
      m_trapped = 1'b0; m_valid = 1'b1; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (redirect_valid) begin
        dest = redirect_target;
`ifdef PC_RAS_EN
        if (redirect_is_ret) begin
          if (m_ras.size() > 0) dest = m_ras.pop_back();
        end else if (redirect_is_call) begin
          if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 32'd4);
        end
`endif
        if (dest % 4 != 0) begin
          m_pc = TRAP_VEC; m_bad = dest; m_mis = 1'b1;
          m_valid = 1'b0; m_trapped = 1'b1;
        end else begin
          m_pc = dest;
        end
      end else if (address_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let the DUT and model advance on the rising
  // edge, then return at the next falling edge for sampling.
  task automatic step(input logic r, input logic rdy, input logic rv,
                      input logic [31:0] tgt, input logic call, input logic ret);
    rst = r; address_ready = rdy; redirect_valid = rv;
    redirect_target = tgt; redirect_is_call = call; redirect_is_ret = ret;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    address_out, m_pc);
    chk({tag, ".valid"}, {31'b0, address_valid}, {31'b0, m_valid});
    chk({tag, ".mis"},   {31'b0, misalign}, {31'b0, m_mis});
    chk({tag, ".bad"},   bad_addr, m_bad);
  endtask

  typedef struct {
    logic        rst, ready, rv;
    logic [31:0] tgt;
    logic        call, ret;
    logic [31:0] pc;
    logic        valid, mis;
    logic [31:0] bad;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] tgt,
                              logic call, logic ret, logic [31:0] pc,
                              logic valid, logic mis, logic [31:0] bad);
    vec_t v;
    v.rst = r; v.ready = rdy; v.rv = rv; v.tgt = tgt; v.call = call; v.ret = ret;
    v.pc = pc; v.valid = valid; v.mis = mis; v.bad = bad;
    return v;
  endfunction

`ifdef PC_RAS_EN
  task automatic step_pc(input string name, input logic rv, input logic [31:0] tgt,
                         input logic call, input logic ret, input logic [31:0] exp_pc);
    step(1'b0, 1'b1, rv, tgt, call, ret);
    chk(name, address_out, exp_pc);
    chk({name, ".valid"}, {31'b0, address_valid}, 32'd1);
  endtask
`endif

  initial begin
    rst = 1'b1; address_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; redirect_is_call = 1'b0; redirect_is_ret = 1'b0;
    @(negedge clk);

    //        rst rdy rv  target        cl re  pc            v  mis bad
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'hC,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h10,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h200,      0, 0, 32'h200,      1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h203,      0, 0, 32'h100,      0, 1, 32'h203));
    vecs.push_back(mk(0, 1, 1, 32'h400,      0, 0, 32'h100,      1, 0, 32'h203));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h104,      1, 0, 32'h203));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 1, 0, 32'h203));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h203));
    vecs.push_back(mk(0, 1, 1, 32'h2,        0, 0, 32'h100,      0, 1, 32'h2));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h500,      0, 0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h800,      0, 0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h600,      0, 1, 32'h600,      1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h700,      1, 0, 32'h700,      1, 0, 32'h0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ready, vecs[i].rv, vecs[i].tgt, vecs[i].call, vecs[i].ret);
      chk($sformatf("vec%0d.pc", i),    address_out, vecs[i].pc);
      chk($sformatf("vec%0d.valid", i), {31'b0, address_valid}, {31'b0, vecs[i].valid});
      chk($sformatf("vec%0d.mis", i),   {31'b0, misalign}, {31'b0, vecs[i].mis});
      chk($sformatf("vec%0d.bad", i),   bad_addr, vecs[i].bad);
    end

`ifdef PC_RAS_EN
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step_pc("ras.to40",  1'b1, 32'h40,  1'b0, 1'b0, 32'h40);
    step_pc("ras.call",  1'b1, 32'h300, 1'b1, 1'b0, 32'h300);
    step_pc("ras.ret",   1'b1, 32'h999, 1'b0, 1'b1, 32'h44);
    for (int i = 1; i <= 5; i++)
      step_pc($sformatf("ras.call%0d", i), 1'b1, 32'(i) * 32'h1000, 1'b1, 1'b0, 32'(i) * 32'h1000);
    for (int i = 0; i < 4; i++)
      step_pc($sformatf("ras.ret%0d", i), 1'b1, 32'hA00, 1'b0, 1'b1, 32'(4 - i) * 32'h1000 + 32'h4);
    step_pc("ras.ret_empty", 1'b1, 32'hA00, 1'b0, 1'b1, 32'hA00);
    step_pc("ras.call_b00",  1'b1, 32'hB00, 1'b1, 1'b0, 32'hB00);
    step_pc("ras.both",      1'b1, 32'hC00, 1'b1, 1'b1, 32'hA04);
    step_pc("ras.after_both", 1'b1, 32'hD00, 1'b0, 1'b1, 32'hD00);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [31:0] tgt;
      int          kind;
      kind = $urandom_range(0, 15);
      if (kind == 0)      tgt = $urandom | 32'h1;
      else if (kind == 1) tgt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      else                tgt = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, tgt,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
